// File: rtl/ram_stream_pkg.sv
// ram_stream_pkg: shared types for the RAM read-side stream controller.
package ram_stream_pkg;

  // Sweep controller states.
  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    DRAIN,
    DONE
  } state_t;

  // Word width of the standard build (the RAM stores int).
  localparam int unsigned WORD_WIDTH = 32;

  // One output FIFO entry for the standard build: a RAM word plus its last-beat tag.
  typedef struct packed {
    logic [WORD_WIDTH-1:0] data;
    logic                  last;
  } fifo_entry_t;

endpackage

// File: rtl/stream_skid_fifo.sv
// stream_skid_fifo: 2-entry FIFO that sits between the RAM read data and the stream port.
// A push and a pop in the same cycle are both honoured and leave the count unchanged.
module stream_skid_fifo #(
  parameter int WIDTH = 33
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head_data,
  output logic             head_valid,
  output logic [1:0]       count
);

  logic [WIDTH-1:0] mem [2];
  logic             wr_ptr;
  logic             rd_ptr;
  logic             pop_ok;

  assign pop_ok     = pop && (count != 2'd0);
  assign head_valid = (count != 2'd0);
  assign head_data  = mem[rd_ptr];

  // Storage, pointers and occupancy; a full FIFO being popped can accept a push into the freed slot.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem[0] <= '0;
      mem[1] <= '0;
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count  <= 2'd0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= ~wr_ptr;
      end
      if (pop_ok) begin
        rd_ptr <= ~rd_ptr;
      end
      count <= count + {1'b0, push} - {1'b0, pop_ok};
    end
  end

  // The producer's credit scheme must never push into a full FIFO that is not being popped.
  assert property (@(posedge clk) disable iff (!rst_n) !(push && !pop_ok && (count == 2'd2)));

endmodule

// File: rtl/ram_stream_reader.sv
// ram_stream_reader: sweeps RAM port B over 0..DATA_AMOUNT-1 after a start edge and
// presents the registered read data as a valid/ready stream with a last-beat marker.
module ram_stream_reader
  import ram_stream_pkg::*;
#(
  parameter  int DATA_WIDTH  = 32,
  parameter  int DEPTH       = 16,
  parameter  int DATA_AMOUNT = 16,
  localparam int ADDR_WIDTH  = $clog2(DEPTH)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  output logic [ADDR_WIDTH-1:0] ram_addr,
  input  logic [DATA_WIDTH-1:0] ram_dout,
  output logic [DATA_WIDTH-1:0] m_data,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic                  m_last,
  output logic                  busy,
  output logic                  done
);

  typedef struct packed {
    logic [DATA_WIDTH-1:0] data;
    logic                  last;
  } entry_t;

  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(DATA_AMOUNT - 1);

  state_t                state;
  state_t                state_next;
  logic                  start_q;
  logic                  start_rise;
  logic [ADDR_WIDTH-1:0] issue_cnt;
  logic                  issue;
  logic                  issue_last;
  logic                  can_issue;
  logic                  addr_pending;
  logic                  addr_last;
  logic                  dout_pending;
  logic                  dout_last;
  logic                  push;
  logic                  pop;
  logic                  room;
  logic [1:0]            fifo_count;
  logic [1:0]            count_after;
  entry_t                push_entry;
  entry_t                head_entry;
  logic                  head_valid;

  // addr_pending: an address went out on the last edge, its word reaches ram_dout next cycle.
  // dout_pending: ram_dout holds a requested word not yet in the FIFO. While no new address
  // is issued, ram_addr holds and the RAM keeps re-reading the same word, so that word can
  // wait on ram_dout; once ram_addr moves on it has to be pushed on the very next edge.
  // A new issue is therefore allowed only if any waiting word is taken now and, when another
  // read is already in flight, the FIFO is guaranteed room for it on the following edge.
  assign start_rise  = start && !start_q;
  assign pop         = head_valid && m_ready;
  assign room        = (fifo_count != 2'd2) || pop;
  assign push        = dout_pending && room;
  assign count_after = fifo_count + {1'b0, push} - {1'b0, pop};
  assign can_issue   = !(dout_pending && !push) && (!addr_pending || (count_after <= 2'd1));
  assign issue_last  = (issue_cnt == LAST_ADDR);
  assign push_entry  = {ram_dout, dout_last};

  assign m_valid = head_valid;
  assign m_data  = head_valid ? head_entry.data : '0;
  assign m_last  = head_valid && head_entry.last;

  stream_skid_fifo #(
    .WIDTH($bits(entry_t))
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (push),
    .push_data (push_entry),
    .pop       (pop),
    .head_data (head_entry),
    .head_valid(head_valid),
    .count     (fifo_count)
  );

  // Next-state, read-issue and status decode for the sweep controller.
  always_comb begin
    state_next = state;
    issue      = 1'b0;
    busy       = 1'b0;
    done       = 1'b0;
    unique case (state)
      IDLE: begin
        if (start_rise) begin
          issue      = 1'b1;
          state_next = issue_last ? DRAIN : ISSUE;
        end
      end
      ISSUE: begin
        busy = 1'b1;
        if (can_issue) begin
          issue = 1'b1;
          if (issue_last) begin
            state_next = DRAIN;
          end
        end
      end
      DRAIN: begin
        busy = 1'b1;
        if (pop && m_last) begin
          state_next = DONE;
        end
      end
      DONE: begin
        done       = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // State register, start edge history, address generation and read-latency tracking.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      start_q      <= 1'b0;
      issue_cnt    <= '0;
      ram_addr     <= '0;
      addr_pending <= 1'b0;
      addr_last    <= 1'b0;
      dout_pending <= 1'b0;
      dout_last    <= 1'b0;
    end else begin
      state   <= state_next;
      start_q <= start;
      if (issue) begin
        ram_addr  <= issue_cnt;
        issue_cnt <= issue_cnt + ADDR_WIDTH'(1);
      end else if (state == DONE) begin
        ram_addr  <= '0;
        issue_cnt <= '0;
      end
      addr_pending <= issue;
      addr_last    <= issue && issue_last;
      dout_pending <= addr_pending || (dout_pending && !push);
      if (addr_pending) begin
        dout_last <= addr_last;
      end
    end
  end

  // A word whose address has already been replaced must land in the FIFO on this edge.
  assert property (@(posedge clk) disable iff (!rst_n) !(addr_pending && dout_pending && !push));

endmodule

// File: tb/tb_ram_stream_reader.sv
// tb_ram_stream_reader: directed bench for ram_stream_reader with behavioural dual-port RAMs.
module tb_ram_stream_reader;

  typedef struct {
    logic        ready;
    logic        valid;
    logic [31:0] data;
    logic        last;
    logic        busy;
    logic        done;
    logic [3:0]  addr;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic        start_drv;
  logic        live_mode;
  logic [3:0]  ram_addr;
  logic [31:0] ram_dout;
  logic [31:0] m_data;
  logic        m_valid;
  logic        m_ready;
  logic        m_last;
  logic        busy;
  logic        done;

  logic        we;
  logic [3:0]  waddr;
  logic [31:0] wdata;
  logic        ram_avail;
  logic [31:0] mem [16];

  logic        start1;
  logic [1:0]  ram_addr1;
  logic [31:0] ram_dout1;
  logic [31:0] m_data1;
  logic        m_valid1;
  logic        m_ready1;
  logic        m_last1;
  logic        busy1;
  logic        done1;

  int checks = 0;
  int errors = 0;
  vec_t vecs [20];

  assign start = live_mode ? ram_avail : start_drv;

  always #5 clk = ~clk;

  // Port A write / port B registered read, like the team's simple dual-port RAM.
  always @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    ram_dout <= mem[ram_addr];
  end

  // Small RAM for the single-word build: word 0 holds 42.
  always @(posedge clk) begin
    ram_dout1 <= (ram_addr1 == 2'd0) ? 32'd42 : 32'd0;
  end

  ram_stream_reader #(
    .DATA_WIDTH (32),
    .DEPTH      (16),
    .DATA_AMOUNT(16)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (start),
    .ram_addr(ram_addr),
    .ram_dout(ram_dout),
    .m_data  (m_data),
    .m_valid (m_valid),
    .m_ready (m_ready),
    .m_last  (m_last),
    .busy    (busy),
    .done    (done)
  );

  ram_stream_reader #(
    .DATA_WIDTH (32),
    .DEPTH      (4),
    .DATA_AMOUNT(1)
  ) dut1 (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (start1),
    .ram_addr(ram_addr1),
    .ram_dout(ram_dout1),
    .m_data  (m_data1),
    .m_valid (m_valid1),
    .m_ready (m_ready1),
    .m_last  (m_last1),
    .busy    (busy1),
    .done    (done1)
  );

  task automatic check_output(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, actual, expected);
    end
  endtask

  task automatic apply_stimulus(input int k, input vec_t v);
    m_ready = v.ready;
    check_output($sformatf("b2b_valid_c%0d", k), 32'(m_valid), 32'(v.valid));
    check_output($sformatf("b2b_busy_c%0d", k), 32'(busy), 32'(v.busy));
    check_output($sformatf("b2b_done_c%0d", k), 32'(done), 32'(v.done));
    check_output($sformatf("b2b_addr_c%0d", k), 32'(ram_addr), 32'(v.addr));
    if (v.valid) begin
      check_output($sformatf("b2b_data_c%0d", k), m_data, v.data);
      check_output($sformatf("b2b_last_c%0d", k), 32'(m_last), 32'(v.last));
    end
  endtask

  task automatic pulse_start();
    start_drv = 1'b1;
    @(posedge clk); #1;
    start_drv = 1'b0;
  endtask

  task automatic fill_ram(input int base, input int step);
    ram_avail = 1'b0;
    for (int i = 0; i < 16; i++) begin
      we    = 1'b1;
      waddr = 4'(i);
      wdata = 32'(base + step * i);
      @(posedge clk); #1;
    end
    we        = 1'b0;
    ram_avail = 1'b1;
  endtask

  // Drain one sweep, scoring every transferred beat, stall stability and the done pulse.
  task automatic run_sweep(input int ready_mode, input int base, input int step, input int n_exp,
                           input int glitch_beat, input string tag);
    int          beats = 0;
    int          dones = 0;
    int          cyc = 0;
    int          post = -1;
    logic        prev_stall = 1'b0;
    logic [31:0] prev_data = '0;
    while (cyc < 300 && post != 0) begin
      m_ready = (ready_mode == 0) ? 1'b1 : ((cyc % 4 == 0) || (cyc % 4 == 3));
      if (glitch_beat >= 0) start_drv = (beats == glitch_beat);
      if (prev_stall) begin
        check_output($sformatf("%s_hold_valid", tag), 32'(m_valid), 32'd1);
        check_output($sformatf("%s_hold_data", tag), m_data, prev_data);
      end
      if (m_valid && m_ready) begin
        check_output($sformatf("%s_data_%0d", tag, beats), m_data, 32'(base + step * beats));
        check_output($sformatf("%s_last_%0d", tag, beats), 32'(m_last), 32'(beats == n_exp - 1));
        beats++;
      end
      prev_stall = m_valid && !m_ready;
      prev_data  = m_data;
      if (done) begin
        dones++;
        if (post < 0) post = 4;
      end
      if (post > 0) post--;
      @(posedge clk); #1;
      cyc++;
    end
    check_output($sformatf("%s_finished", tag), 32'(post == 0), 32'd1);
    check_output($sformatf("%s_beats", tag), 32'(beats), 32'(n_exp));
    check_output($sformatf("%s_done_pulses", tag), 32'(dones), 32'd1);
  endtask

  initial begin
    int beats;
    int cyc;
    int busy_cycles;

    rst_n     = 1'b0;
    start_drv = 1'b0;
    live_mode = 1'b0;
    m_ready   = 1'b0;
    we        = 1'b0;
    waddr     = '0;
    wdata     = '0;
    ram_avail = 1'b0;
    start1    = 1'b0;
    m_ready1  = 1'b0;

    for (int k = 1; k <= 20; k++) begin
      vecs[k-1].ready = 1'b1;
      vecs[k-1].valid = (k >= 3) && (k <= 18);
      vecs[k-1].data  = 32'(100 + k - 3);
      vecs[k-1].last  = (k == 18);
      vecs[k-1].busy  = (k <= 18);
      vecs[k-1].done  = (k == 19);
      vecs[k-1].addr  = (k <= 16) ? 4'(k - 1) : ((k <= 19) ? 4'd15 : 4'd0);
    end

    @(posedge clk); @(posedge clk); #1;
    check_output("rst_ram_addr", 32'(ram_addr), 32'd0);
    check_output("rst_m_data", m_data, 32'd0);
    check_output("rst_m_valid", 32'(m_valid), 32'd0);
    check_output("rst_m_last", 32'(m_last), 32'd0);
    check_output("rst_busy", 32'(busy), 32'd0);
    check_output("rst_done", 32'(done), 32'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    $display("[TB] back-to-back sweep");
    fill_ram(100, 1);
    @(posedge clk); #1;
    pulse_start();
    for (int k = 1; k <= 20; k++) begin
      apply_stimulus(k, vecs[k-1]);
      @(posedge clk); #1;
    end

    $display("[TB] backpressure sweep");
    pulse_start();
    run_sweep(1, 100, 1, 16, -1, "bp");

    $display("[TB] start held high");
    start_drv = 1'b1;
    run_sweep(0, 100, 1, 16, -1, "held");
    busy_cycles = 0;
    for (int i = 0; i < 17; i++) begin
      if (busy || m_valid) busy_cycles++;
      @(posedge clk); #1;
    end
    check_output("held_no_second_sweep", 32'(busy_cycles), 32'd0);
    start_drv = 1'b0;
    @(posedge clk); #1;

    $display("[TB] second start edge during sweep");
    pulse_start();
    run_sweep(0, 100, 1, 16, 5, "glitch");
    repeat (5) begin
      @(posedge clk); #1;
    end
    check_output("glitch_idle_after", 32'(busy), 32'd0);

    $display("[TB] reset mid-sweep");
    pulse_start();
    m_ready = 1'b1;
    beats   = 0;
    cyc     = 0;
    while (beats < 8 && cyc < 60) begin
      if (m_valid && m_ready) beats++;
      @(posedge clk); #1;
      cyc++;
    end
    check_output("abort_reached_beat7", 32'(beats), 32'd8);
    #2 rst_n = 1'b0;
    #1;
    check_output("abort_ram_addr", 32'(ram_addr), 32'd0);
    check_output("abort_m_data", m_data, 32'd0);
    check_output("abort_m_valid", 32'(m_valid), 32'd0);
    check_output("abort_m_last", 32'(m_last), 32'd0);
    check_output("abort_busy", 32'(busy), 32'd0);
    check_output("abort_done", 32'(done), 32'd0);
    @(posedge clk); @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    check_output("abort_stays_idle", 32'(busy), 32'd0);
    pulse_start();
    run_sweep(0, 100, 1, 16, -1, "restart");

    $display("[TB] single-word sweep");
    m_ready1 = 1'b1;
    start1   = 1'b1;
    @(posedge clk); #1;
    start1 = 1'b0;
    check_output("one_busy_c1", 32'(busy1), 32'd1);
    check_output("one_valid_c1", 32'(m_valid1), 32'd0);
    @(posedge clk); #1;
    check_output("one_valid_c2", 32'(m_valid1), 32'd0);
    @(posedge clk); #1;
    check_output("one_valid_c3", 32'(m_valid1), 32'd1);
    check_output("one_data_c3", m_data1, 32'd42);
    check_output("one_last_c3", 32'(m_last1), 32'd1);
    check_output("one_done_c3", 32'(done1), 32'd0);
    @(posedge clk); #1;
    check_output("one_done_c4", 32'(done1), 32'd1);
    check_output("one_valid_c4", 32'(m_valid1), 32'd0);
    check_output("one_busy_c4", 32'(busy1), 32'd0);
    @(posedge clk); #1;
    check_output("one_done_c5", 32'(done1), 32'd0);

    $display("[TB] live fill with start on read_ram_available");
    ram_avail = 1'b0;
    @(posedge clk); #1;
    live_mode = 1'b1;
    @(posedge clk); #1;
    check_output("live_idle_during_fill", 32'(busy), 32'd0);
    fill_ram(500, 3);
    run_sweep(0, 500, 3, 16, -1, "live");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation did not reach the end");
    $fatal(1, "[TB] watchdog");
  end

endmodule
